// File: rtl/screen_buffer_write_ctrl_pkg.sv
// Shared screen-buffer types and NES frame geometry.
// Used by the write controller, the VGA scan-out side and the palette logic.
// Pure declarations; no logic.
package screen_buf_pkg;

  localparam int NES_COLS     = 256;
  localparam int NES_LINES    = 240;
  localparam int PAL_W        = 6;
  localparam int NES_COL_BITS = 8;
  localparam int NES_ROW_BITS = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    VBLANK = 2'd2
  } wr_state_e;

  // Buffer address as seen on the write port: row in the upper bits.
  typedef struct packed {
    logic [NES_ROW_BITS-1:0] row;
    logic [NES_COL_BITS-1:0] col;
  } buf_addr_t;

endpackage

// File: rtl/screen_buffer_write_ctrl_counter.sv
// Column/row/line counters for the PPU pixel stream.
// Combinational address for the pixel being accepted this cycle; counters update on the clock.
// No backpressure: advances on every accepted pixel, clear restarts the frame.
module pixel_addr_counter #(
  parameter int COLS      = 256,
  parameter int LINES     = 240,
  parameter int COL_BITS  = 8,
  parameter int ROW_BITS  = 5,
  parameter int LINE_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_i,
  input  logic                adv_i,
  output logic [COL_BITS-1:0] pix_col_o,
  output logic [ROW_BITS-1:0] pix_row_o,
  output logic                line_wrap_o,
  output logic                frame_end_o
);

  logic [COL_BITS-1:0]  col_q, col_d, col_base;
  logic [ROW_BITS-1:0]  row_q, row_d, row_base;
  logic [LINE_BITS-1:0] line_q, line_d, line_base;

  // A frame restart makes the current pixel land on {0,0}, so the counters
  // are zeroed before the advance is applied.
  always_comb begin
    col_base  = clear_i ? '0 : col_q;
    row_base  = clear_i ? '0 : row_q;
    line_base = clear_i ? '0 : line_q;

    pix_col_o   = col_base;
    pix_row_o   = row_base;
    line_wrap_o = adv_i && (col_base == COL_BITS'(COLS - 1));
    frame_end_o = line_wrap_o && (line_base == LINE_BITS'(LINES - 1));

    col_d  = col_base;
    row_d  = row_base;
    line_d = line_base;
    if (adv_i) begin
      if (line_wrap_o) begin
        col_d  = '0;
        row_d  = row_base + ROW_BITS'(1);
        line_d = line_base + LINE_BITS'(1);
      end else begin
        col_d = col_base + COL_BITS'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      line_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/screen_buffer_write_ctrl.sv
// Screen-buffer write sequencer: PPU pixels to {row,col} writes, debug writer shares the port.
// Latency 1 cycle from accepted pixel or debug grant to the registered write.
// PPU never stalls; a debug request waits (req held) until a pixel-free cycle, then gets one ack.
module screen_buffer_write_ctrl
  import screen_buf_pkg::*;
#(
  parameter int COLS     = NES_COLS,
  parameter int LINES    = NES_LINES,
  parameter int COL_BITS = NES_COL_BITS,
  parameter int ROW_BITS = NES_ROW_BITS,
  parameter int DATA_W   = PAL_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic                         pix_valid,
  input  logic [DATA_W-1:0]            pix_data,
  input  logic                         dbg_req,
  input  logic [ROW_BITS+COL_BITS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]            dbg_data,
  output logic                         dbg_ack,
  output logic                         wr_en,
  output logic [ROW_BITS+COL_BITS-1:0] wr_addr,
  output logic [DATA_W-1:0]            wr_data,
  output logic                         line_done,
  output logic [ROW_BITS-1:0]          line_row,
  output logic                         in_vblank,
  output logic [7:0]                   stray_cnt
);

  localparam int LINE_BITS = $clog2(LINES + 1);
  localparam int AW        = ROW_BITS + COL_BITS;

  wr_state_e           state_q, state_d;
  logic                accept, grant;
  logic [COL_BITS-1:0] pix_col;
  logic [ROW_BITS-1:0] pix_row;
  logic                line_wrap, frame_end;

  logic                wr_en_q, wr_en_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                dbg_ack_q, dbg_ack_d;
  logic                line_done_q, line_done_d;
  logic [ROW_BITS-1:0] line_row_q, line_row_d;
  logic                in_vblank_q, in_vblank_d;
  logic [7:0]          stray_q, stray_d;

  pixel_addr_counter #(
    .COLS      (COLS),
    .LINES     (LINES),
    .COL_BITS  (COL_BITS),
    .ROW_BITS  (ROW_BITS),
    .LINE_BITS (LINE_BITS)
  ) u_cnt (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (frame_start),
    .adv_i       (accept),
    .pix_col_o   (pix_col),
    .pix_row_o   (pix_row),
    .line_wrap_o (line_wrap),
    .frame_end_o (frame_end)
  );

  // Next state, port arbitration and output staging.
  always_comb begin
    // A frame sync makes the coincident pixel the first of the new frame.
    accept = pix_valid && (frame_start || (state_q == ACTIVE));
    // No grant while ack is out, so a held request is written only once.
    grant  = dbg_req && !accept && !dbg_ack_q;

    state_d = state_q;
    if (frame_start) begin
      state_d = ACTIVE;
    end else if ((state_q == ACTIVE) && frame_end) begin
      state_d = VBLANK;
    end

    wr_en_d   = accept || grant;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (accept) begin
      wr_addr_d = {pix_row, pix_col};
      wr_data_d = pix_data;
    end else if (grant) begin
      wr_addr_d = dbg_addr;
      wr_data_d = dbg_data;
    end

    dbg_ack_d   = grant;
    line_done_d = line_wrap;
    line_row_d  = line_wrap ? pix_row : line_row_q;
    in_vblank_d = (state_d == VBLANK);

    stray_d = stray_q;
    if (pix_valid && !accept && (stray_q != 8'hFF)) begin
      stray_d = stray_q + 8'd1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      dbg_ack_q   <= 1'b0;
      line_done_q <= 1'b0;
      line_row_q  <= '0;
      in_vblank_q <= 1'b0;
      stray_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      dbg_ack_q   <= dbg_ack_d;
      line_done_q <= line_done_d;
      line_row_q  <= line_row_d;
      in_vblank_q <= in_vblank_d;
      stray_q     <= stray_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign dbg_ack   = dbg_ack_q;
  assign line_done = line_done_q;
  assign line_row  = line_row_q;
  assign in_vblank = in_vblank_q;
  assign stray_cnt = stray_q;

endmodule

// File: tb/tb_screen_buffer_write_ctrl.sv
// Directed bench for screen_buffer_write_ctrl.
module tb_screen_buffer_write_ctrl;
  import screen_buf_pkg::*;

  logic        clk = 1'b0;
  logic        reset, frame_start, pix_valid, dbg_req;
  logic [5:0]  pix_data, dbg_data;
  logic [12:0] dbg_addr;
  logic        dbg_ack, wr_en, line_done, in_vblank;
  logic [12:0] wr_addr;
  logic [5:0]  wr_data;
  logic [4:0]  line_row;
  logic [7:0]  stray_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  screen_buffer_write_ctrl dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ack(dbg_ack),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .line_done(line_done), .line_row(line_row), .in_vblank(in_vblank), .stray_cnt(stray_cnt)
  );

  function automatic logic [12:0] a(input int r, input int c);
    buf_addr_t x;
    x.row = 5'(r);
    x.col = 8'(c);
    return x;
  endfunction

  // Advance one clock and settle past the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    dbg_req = 1'b0; dbg_addr = '0; dbg_data = '0;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    dbg_req = 1'b0; dbg_addr = '0; dbg_data = '0;
    tick;
    n_checks++; if (wr_en !== 1'b0)     begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    n_checks++; if (wr_addr !== 13'd0)  begin n_fail++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
    n_checks++; if (wr_data !== 6'd0)   begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    n_checks++; if (dbg_ack !== 1'b0)   begin n_fail++; $display("FAIL reset_dbg_ack: got %b want 0", dbg_ack); end
    n_checks++; if (line_done !== 1'b0) begin n_fail++; $display("FAIL reset_line_done: got %b want 0", line_done); end
    n_checks++; if (line_row !== 5'd0)  begin n_fail++; $display("FAIL reset_line_row: got %0d want 0", line_row); end
    n_checks++; if (in_vblank !== 1'b0) begin n_fail++; $display("FAIL reset_in_vblank: got %b want 0", in_vblank); end
    n_checks++; if (stray_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_stray: got %0d want 0", stray_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_first_line;
    int bad, ld;
    apply_reset;
    frame_start = 1'b1; tick; frame_start = 1'b0;
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL line_sync_no_write: wr_en %b want 0", wr_en); end
    bad = 0; ld = 0;
    for (int i = 0; i < 256; i++) begin
      pix_valid = 1'b1; pix_data = 6'(i % 64); tick;
      if (wr_en !== 1'b1 || wr_addr !== a(0, i) || wr_data !== 6'(i % 64)) bad++;
      if (line_done === 1'b1) ld++;
      if (i == 255) begin
        n_checks++; if (line_done !== 1'b1 || line_row !== 5'd0)
          begin n_fail++; $display("FAIL line_done_last: done %b row %0d want 1/0", line_done, line_row); end
      end
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL line_writes: %0d bad writes want 0", bad); end
    n_checks++; if (ld !== 1) begin n_fail++; $display("FAIL line_done_count: %0d pulses want 1", ld); end
    pix_data = 6'h3F; tick; pix_valid = 1'b0;
    n_checks++; if (wr_addr !== a(1, 0) || line_done !== 1'b0)
      begin n_fail++; $display("FAIL line_col_wrap: addr %h done %b want %h/0", wr_addr, line_done, a(1, 0)); end
    tick;
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL line_idle: wr_en %b want 0", wr_en); end
  endtask

  task automatic test_full_frame;
    int bad, ld, wen;
    logic [12:0] wrap_addr;
    logic [4:0]  row31;
    logic        vb_early;
    wrap_addr = '1; row31 = '0; vb_early = 1'b1;
    apply_reset;
    frame_start = 1'b1; tick; frame_start = 1'b0;
    for (int l = 0; l < 240; l++) begin
      bad = 0; ld = 0;
      for (int c = 0; c < 256; c++) begin
        pix_valid = 1'b1; pix_data = 6'((l + c) % 64); tick;
        if (wr_en !== 1'b1 || wr_addr !== a(l % 32, c) || wr_data !== 6'((l + c) % 64)) bad++;
        if (line_done === 1'b1) begin
          ld++;
          if (c != 255 || line_row !== 5'(l % 32)) bad++;
        end
        if (l == 32 && c == 0) wrap_addr = wr_addr;
        if (l == 31 && c == 255) row31 = line_row;
        if (l == 239 && c == 254) vb_early = in_vblank;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL frame_line%0d: %0d bad writes want 0", l, bad); end
      n_checks++; if (ld !== 1) begin n_fail++; $display("FAIL frame_done%0d: %0d pulses want 1", l, ld); end
    end
    n_checks++; if (in_vblank !== 1'b1) begin n_fail++; $display("FAIL frame_vblank: got %b want 1", in_vblank); end
    n_checks++; if (vb_early !== 1'b0) begin n_fail++; $display("FAIL frame_vblank_early: got %b want 0", vb_early); end
    n_checks++; if (wrap_addr !== a(0, 0)) begin n_fail++; $display("FAIL frame_row_wrap: got %h want %h", wrap_addr, a(0, 0)); end
    n_checks++; if (row31 !== 5'd31) begin n_fail++; $display("FAIL frame_row31: got %0d want 31", row31); end
    wen = 0;
    for (int i = 0; i < 5; i++) begin
      pix_data = 6'(i); tick;
      if (wr_en !== 1'b0) wen++;
    end
    n_checks++; if (wen !== 0) begin n_fail++; $display("FAIL vblank_no_write: %0d writes want 0", wen); end
    n_checks++; if (stray_cnt !== 8'd5) begin n_fail++; $display("FAIL vblank_stray: got %0d want 5", stray_cnt); end
    frame_start = 1'b1; pix_data = 6'h07; tick; frame_start = 1'b0; pix_valid = 1'b0;
    n_checks++; if (wr_en !== 1'b1 || wr_addr !== a(0, 0) || wr_data !== 6'h07 || in_vblank !== 1'b0)
      begin n_fail++; $display("FAIL vblank_resync: en %b addr %h data %h vb %b want 1/0000/07/0", wr_en, wr_addr, wr_data, in_vblank); end
  endtask

  task automatic test_dbg_gap;
    apply_reset;
    frame_start = 1'b1; tick; frame_start = 1'b0;
    dbg_req = 1'b1; dbg_addr = a(3, 10); dbg_data = 6'h2A; tick;
    n_checks++; if (wr_en !== 1'b1 || wr_addr !== a(3, 10) || wr_data !== 6'h2A || dbg_ack !== 1'b1)
      begin n_fail++; $display("FAIL dbg_write: en %b addr %h data %h ack %b want 1/%h/2a/1", wr_en, wr_addr, wr_data, dbg_ack, a(3, 10)); end
    tick;
    n_checks++; if (wr_en !== 1'b0 || dbg_ack !== 1'b0)
      begin n_fail++; $display("FAIL dbg_single: en %b ack %b want 0/0", wr_en, dbg_ack); end
    dbg_req = 1'b0; tick;
    n_checks++; if (wr_en !== 1'b0 || wr_addr !== a(3, 10))
      begin n_fail++; $display("FAIL dbg_hold: en %b addr %h want 0/%h", wr_en, wr_addr, a(3, 10)); end
  endtask

  task automatic test_dbg_blocked;
    int bad;
    apply_reset;
    frame_start = 1'b1; tick; frame_start = 1'b0;
    dbg_req = 1'b1; dbg_addr = a(7, 200); dbg_data = 6'h15;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      pix_valid = 1'b1; pix_data = 6'(8'h30 + i); tick;
      if (wr_en !== 1'b1 || wr_addr !== a(0, i) || wr_data !== 6'(8'h30 + i) || dbg_ack !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL blocked_pixels: %0d bad cycles want 0", bad); end
    pix_valid = 1'b0; tick;
    n_checks++; if (wr_en !== 1'b1 || wr_addr !== a(7, 200) || wr_data !== 6'h15 || dbg_ack !== 1'b1)
      begin n_fail++; $display("FAIL blocked_grant: en %b addr %h data %h ack %b want 1/%h/15/1", wr_en, wr_addr, wr_data, dbg_ack, a(7, 200)); end
    dbg_req = 1'b0; tick;
    n_checks++; if (wr_en !== 1'b0 || wr_addr !== a(7, 200) || wr_data !== 6'h15)
      begin n_fail++; $display("FAIL blocked_hold: en %b addr %h data %h want 0/%h/15", wr_en, wr_addr, wr_data, a(7, 200)); end
  endtask

  task automatic test_midline_sync;
    int ld;
    apply_reset;
    frame_start = 1'b1; tick; frame_start = 1'b0;
    for (int i = 0; i < 5 * 256 + 100; i++) begin
      pix_valid = 1'b1; pix_data = 6'(i % 64); tick;
    end
    n_checks++; if (wr_addr !== a(5, 99)) begin n_fail++; $display("FAIL mid_position: got %h want %h", wr_addr, a(5, 99)); end
    ld = 0;
    frame_start = 1'b1; pix_data = 6'h11; tick; frame_start = 1'b0;
    if (line_done === 1'b1) ld++;
    n_checks++; if (wr_en !== 1'b1 || wr_addr !== a(0, 0) || wr_data !== 6'h11)
      begin n_fail++; $display("FAIL mid_sync_pixel: en %b addr %h data %h want 1/0000/11", wr_en, wr_addr, wr_data); end
    pix_data = 6'h12; tick; pix_valid = 1'b0;
    if (line_done === 1'b1) ld++;
    n_checks++; if (wr_en !== 1'b1 || wr_addr !== a(0, 1) || wr_data !== 6'h12)
      begin n_fail++; $display("FAIL mid_next_pixel: en %b addr %h data %h want 1/%h/12", wr_en, wr_addr, wr_data, a(0, 1)); end
    n_checks++; if (ld !== 0) begin n_fail++; $display("FAIL mid_no_line_done: %0d pulses want 0", ld); end
  endtask

  task automatic test_stray_and_reset;
    int wen;
    apply_reset;
    wen = 0;
    for (int i = 0; i < 300; i++) begin
      pix_valid = 1'b1; pix_data = 6'(i % 64); tick;
      if (wr_en !== 1'b0) wen++;
    end
    n_checks++; if (wen !== 0) begin n_fail++; $display("FAIL stray_no_write: %0d writes want 0", wen); end
    n_checks++; if (stray_cnt !== 8'd255) begin n_fail++; $display("FAIL stray_saturate: got %0d want 255", stray_cnt); end
    frame_start = 1'b1; pix_valid = 1'b0; tick; frame_start = 1'b0;
    for (int i = 0; i < 515; i++) begin
      pix_valid = 1'b1; pix_data = 6'(i % 64); tick;
    end
    n_checks++; if (line_row !== 5'd1 || wr_addr !== a(2, 2))
      begin n_fail++; $display("FAIL pre_reset_state: row %0d addr %h want 1/%h", line_row, wr_addr, a(2, 2)); end
    reset = 1'b1; dbg_req = 1'b1; dbg_addr = a(9, 9); dbg_data = 6'h09; tick;
    n_checks++; if (wr_en !== 1'b0 || wr_addr !== 13'd0 || wr_data !== 6'd0 || dbg_ack !== 1'b0)
      begin n_fail++; $display("FAIL midreset_port: en %b addr %h data %h ack %b want all 0", wr_en, wr_addr, wr_data, dbg_ack); end
    n_checks++; if (line_done !== 1'b0 || line_row !== 5'd0 || in_vblank !== 1'b0 || stray_cnt !== 8'd0)
      begin n_fail++; $display("FAIL midreset_status: done %b row %0d vb %b stray %0d want all 0", line_done, line_row, in_vblank, stray_cnt); end
    reset = 1'b0; pix_valid = 1'b0; tick;
    n_checks++; if (wr_en !== 1'b1 || wr_addr !== a(9, 9) || wr_data !== 6'h09 || dbg_ack !== 1'b1)
      begin n_fail++; $display("FAIL regrant: en %b addr %h data %h ack %b want 1/%h/09/1", wr_en, wr_addr, wr_data, dbg_ack, a(9, 9)); end
    dbg_req = 1'b0; tick;
  endtask

  initial begin
    test_reset;
    test_first_line;
    test_full_frame;
    test_dbg_gap;
    test_dbg_blocked;
    test_midline_sync;
    test_stray_and_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
